// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared definitions for the instruction-fetch / load-store memory arbiter.
//   arb_state_t           : arbiter FSM states (IDLE, BUSY_IF, BUSY_LS)
//   DEFAULT_STARVE_LIMIT  : default cap on consecutive load/store grants
//                           issued while a fetch is left waiting
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_LS = 2'd2
    } arb_state_t;

    localparam int DEFAULT_STARVE_LIMIT = 4;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Arbitrates an instruction-fetch port and a load/store port onto one
// single-port memory. One transaction is in flight at a time.
//
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   if_req/if_addr            fetch request (held until if_gnt)
//   if_gnt/if_rvalid/if_rdata fetch accept, one-cycle data pulse, data
//   ls_req/ls_we/ls_addr/
//   ls_wdata/ls_be            load/store request (held until ls_gnt)
//   ls_gnt/ls_rvalid/ls_rdata load/store accept, completion pulse, load data
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_be          memory request bundle, held while busy
//   mem_ready/mem_rdata       memory completion and read data
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,

    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    input  logic [3:0]  ls_be,
    output logic        ls_gnt,
    output logic        ls_rvalid,
    output logic [31:0] ls_rdata,

    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic              ls_rvalid_q, ls_rvalid_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [31:0]       ls_rdata_q, ls_rdata_d;
    logic              fetch_wins;

    // Memory is word addressed; the byte offset bits are dropped on purpose.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[1:0], ls_addr[1:0]};

    // Load/store normally wins; a waiting fetch takes over once it has been
    // passed over STARVE_LIMIT times in a row.
    assign fetch_wins = if_req && (!ls_req || (starve_q == STARVE_MAX));

    // Next-state, grant and capture logic. Grants are combinational and only
    // possible from IDLE; the accepted request is latched so the memory
    // bundle stays stable however long the memory stalls.
    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        if_rvalid_d = 1'b0;
        ls_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        ls_rdata_d  = ls_rdata_q;
        if_gnt      = 1'b0;
        ls_gnt      = 1'b0;

        case (state_q)
            IDLE: begin
                if (fetch_wins) begin
                    if_gnt   = 1'b1;
                    addr_d   = {if_addr[31:2], 2'b00};
                    we_d     = 1'b0;
                    wdata_d  = 32'h0;
                    be_d     = 4'b1111;
                    starve_d = '0;
                    state_d  = BUSY_IF;
                end else if (ls_req) begin
                    ls_gnt  = 1'b1;
                    addr_d  = {ls_addr[31:2], 2'b00};
                    we_d    = ls_we;
                    wdata_d = ls_wdata;
                    be_d    = ls_be;
                    // Only count grants that actually made a fetch wait.
                    if (if_req && (starve_q != STARVE_MAX)) begin
                        starve_d = starve_q + CNT_W'(1);
                    end
                    state_d = BUSY_LS;
                end
            end
            BUSY_IF: begin
                if (mem_ready) begin
                    if_rdata_d  = mem_rdata;
                    if_rvalid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            BUSY_LS: begin
                if (mem_ready) begin
                    // Stores complete with a pulse but leave ls_rdata alone.
                    if (!we_q) begin
                        ls_rdata_d = mem_rdata;
                    end
                    ls_rvalid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register. Reset drops any in-flight transaction, so a pending
    // completion can never turn into an rvalid afterwards.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            we_q        <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            be_q        <= 4'b0000;
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            if_rdata_q  <= 32'h0;
            ls_rdata_q  <= 32'h0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            if_rvalid_q <= if_rvalid_d;
            ls_rvalid_q <= ls_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
        end
    end

    assign mem_req   = (state_q != IDLE);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;

    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign ls_rvalid = ls_rvalid_q;
    assign ls_rdata  = ls_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Self-checking bench for mem_arbiter: a small word memory answers the
// arbiter with a programmable number of wait states, expected read data and
// expected grant order are queued when stimulus is driven and compared when
// the DUT responds.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_be;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    logic [31:0] if_exp_q[$];
    logic [31:0] ls_exp_q[$];
    byte         gnt_exp_q[$];

    int          wait_states = 0;
    int          busy_cnt    = 0;
    logic [31:0] model_mem [0:63];

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_be     (ls_be),
        .ls_gnt    (ls_gnt),
        .ls_rvalid (ls_rvalid),
        .ls_rdata  (ls_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: answers after wait_states stalled cycles, holds a fetch
    // word at 0x04 after reset, and applies byte-enabled stores.
    assign mem_ready = mem_req && (busy_cnt >= wait_states);
    assign mem_rdata = mem_ready ? model_mem[mem_addr[7:2]] : 32'h0;

    always @(posedge clk) begin
        if (!rst) begin
            busy_cnt <= 0;
            for (int i = 0; i < 64; i++) model_mem[i] <= 32'h0;
            model_mem[1] <= 32'h3E800093;
        end else begin
            if (mem_req && !mem_ready) busy_cnt <= busy_cnt + 1;
            else                       busy_cnt <= 0;
            if (mem_ready && mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be[b]) model_mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Drives one request starting at a negedge and holds it until granted;
    // returns at the negedge of the first busy cycle with the request dropped.
    task automatic drive_req(input bit is_ls, input bit we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] be,
                             output bit granted);
        granted = 1'b0;
        if (is_ls) begin
            ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_wdata = wdata; ls_be = be;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        for (int i = 0; i < 20 && !granted; i++) begin
            #1;
            if (is_ls ? ls_gnt : if_gnt) granted = 1'b1;
            @(negedge clk);
        end
        if (is_ls) ls_req = 1'b0;
        else       if_req = 1'b0;
    endtask

    // Waits (bounded) for the next rvalid pulse on the chosen port.
    task automatic wait_rvalid(input bit is_ls, output bit seen, output logic [31:0] data);
        seen = 1'b0;
        data = 32'h0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (is_ls ? ls_rvalid : if_rvalid) begin
                seen = 1'b1;
                data = is_ls ? ls_rdata : if_rdata;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        if_req = 0; if_addr = 0; ls_req = 0; ls_we = 0; ls_addr = 0; ls_wdata = 0; ls_be = 0;
        repeat (3) @(negedge clk);
        checks++; if ({if_gnt, ls_gnt} !== 2'b00) begin failures++; $display("[TB] FAIL reset_gnt got=%b exp=00", {if_gnt, ls_gnt}); end
        checks++; if ({if_rvalid, ls_rvalid} !== 2'b00) begin failures++; $display("[TB] FAIL reset_rvalid got=%b exp=00", {if_rvalid, ls_rvalid}); end
        checks++; if ({mem_req, mem_we} !== 2'b00) begin failures++; $display("[TB] FAIL reset_mem_req_we got=%b exp=00", {mem_req, mem_we}); end
        checks++; if (mem_be !== 4'h0) begin failures++; $display("[TB] FAIL reset_mem_be got=%h exp=0", mem_be); end
        checks++; if ({mem_addr, mem_wdata} !== 64'h0) begin failures++; $display("[TB] FAIL reset_mem_addr_wdata got=%h exp=0", {mem_addr, mem_wdata}); end
        checks++; if ({if_rdata, ls_rdata} !== 64'h0) begin failures++; $display("[TB] FAIL reset_rdata got=%h exp=0", {if_rdata, ls_rdata}); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fetch();
        bit          g;
        logic [31:0] exp;
        wait_states = 0;
        if_exp_q.push_back(32'h3E800093);
        drive_req(1'b0, 1'b0, 32'h0000_0006, 32'h0, 4'h0, g);
        checks++; if (!g) begin failures++; $display("[TB] FAIL fetch_gnt got=0 exp=1"); end
        checks++; if ({mem_req, mem_we, mem_be} !== 6'b1_0_1111) begin failures++; $display("[TB] FAIL fetch_bundle_ctrl got=%b exp=101111", {mem_req, mem_we, mem_be}); end
        checks++; if (mem_addr !== 32'h0000_0004) begin failures++; $display("[TB] FAIL fetch_mem_addr got=%h exp=00000004", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin failures++; $display("[TB] FAIL fetch_mem_wdata got=%h exp=0", mem_wdata); end
        checks++; if (if_gnt !== 1'b0) begin failures++; $display("[TB] FAIL fetch_busy_gnt got=%b exp=0", if_gnt); end
        @(negedge clk);
        exp = (if_exp_q.size() > 0) ? if_exp_q.pop_front() : 32'hFFFF_FFFF;
        checks++; if (if_rvalid !== 1'b1) begin failures++; $display("[TB] FAIL fetch_rvalid_n2 got=%b exp=1", if_rvalid); end
        checks++; if (if_rdata !== exp) begin failures++; $display("[TB] FAIL fetch_rdata got=%h exp=%h", if_rdata, exp); end
        @(negedge clk);
        checks++; if ({if_rvalid, if_rdata} !== {1'b0, 32'h3E800093}) begin failures++; $display("[TB] FAIL fetch_after_pulse got=%b/%h exp=0/3e800093", if_rvalid, if_rdata); end
    endtask

    task automatic test_store_load();
        bit          g, seen;
        logic [31:0] data, exp;
        wait_states = 0;
        ls_exp_q.push_back(32'h0);
        drive_req(1'b1, 1'b1, 32'h0000_0008, 32'h0000_03FE, 4'b1111, g);
        checks++; if (!g) begin failures++; $display("[TB] FAIL store_gnt got=0 exp=1"); end
        checks++; if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'hF, 32'h8, 32'h3FE}) begin
            failures++; $display("[TB] FAIL store_bundle got=%b%b %h %h %h exp=11 f 00000008 000003fe", mem_req, mem_we, mem_be, mem_addr, mem_wdata);
        end
        wait_rvalid(1'b1, seen, data);
        exp = (ls_exp_q.size() > 0) ? ls_exp_q.pop_front() : 32'hFFFF_FFFF;
        checks++; if (!seen) begin failures++; $display("[TB] FAIL store_rvalid got=none exp=pulse"); end
        checks++; if (data !== exp) begin failures++; $display("[TB] FAIL store_rdata_held got=%h exp=%h", data, exp); end
        // Load issued in the same cycle as the store's completion pulse.
        ls_exp_q.push_back(32'h0000_03FE);
        drive_req(1'b1, 1'b0, 32'h0000_0008, 32'h0, 4'h0, g);
        checks++; if (!g) begin failures++; $display("[TB] FAIL load_gnt got=0 exp=1"); end
        wait_rvalid(1'b1, seen, data);
        exp = (ls_exp_q.size() > 0) ? ls_exp_q.pop_front() : 32'hFFFF_FFFF;
        checks++; if (!seen) begin failures++; $display("[TB] FAIL load_rvalid got=none exp=pulse"); end
        checks++; if (data !== exp) begin failures++; $display("[TB] FAIL load_rdata got=%h exp=%h", data, exp); end
    endtask

    task automatic test_contention();
        int  grants = 0;
        byte got, exp;
        wait_states = 0;
        for (int r = 0; r < 2; r++) begin
            gnt_exp_q.push_back("L"); gnt_exp_q.push_back("L");
            gnt_exp_q.push_back("L"); gnt_exp_q.push_back("L");
            gnt_exp_q.push_back("I");
        end
        if_req = 1'b1; if_addr = 32'h4;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h8;
        for (int c = 0; c < 20; c++) begin
            #1;
            checks++; if (if_gnt && ls_gnt) begin failures++; $display("[TB] FAIL contention_exclusive cycle=%0d got=11 exp=one", c); end
            if (if_gnt || ls_gnt) begin
                got = if_gnt ? "I" : "L";
                exp = (gnt_exp_q.size() > 0) ? gnt_exp_q.pop_front() : "?";
                grants++;
                checks++; if (got != exp) begin failures++; $display("[TB] FAIL contention_order grant=%0d got=%c exp=%c", grants, got, exp); end
            end
            @(negedge clk);
        end
        if_req = 1'b0; ls_req = 1'b0;
        checks++; if (grants != 10) begin failures++; $display("[TB] FAIL contention_count got=%0d exp=10", grants); end
        gnt_exp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_wait_states();
        bit          g;
        logic [31:0] exp;
        wait_states = 3;
        ls_exp_q.push_back(32'h0000_03FE);
        drive_req(1'b1, 1'b0, 32'h0000_0008, 32'h0, 4'h0, g);
        checks++; if (!g) begin failures++; $display("[TB] FAIL wait_gnt got=0 exp=1"); end
        if_req = 1'b1; if_addr = 32'h0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if ({mem_req, mem_we, mem_addr, mem_ready, if_gnt, ls_gnt, ls_rvalid} !== {1'b1, 1'b0, 32'h8, 4'b0000}) begin
                failures++;
                $display("[TB] FAIL wait_stall cycle=%0d got=%b%b %h rdy=%b gnt=%b%b rv=%b exp=10 00000008 rdy=0 gnt=00 rv=0",
                         c, mem_req, mem_we, mem_addr, mem_ready, if_gnt, ls_gnt, ls_rvalid);
            end
            @(negedge clk);
        end
        if_req = 1'b0;
        #1;
        checks++; if ({if_gnt, ls_gnt, ls_rvalid} !== 3'b000) begin failures++; $display("[TB] FAIL wait_ready_cycle got=%b exp=000", {if_gnt, ls_gnt, ls_rvalid}); end
        @(negedge clk);
        exp = (ls_exp_q.size() > 0) ? ls_exp_q.pop_front() : 32'hFFFF_FFFF;
        checks++; if ({ls_rvalid, ls_rdata} !== {1'b1, exp}) begin failures++; $display("[TB] FAIL wait_rvalid got=%b/%h exp=1/%h", ls_rvalid, ls_rdata, exp); end
        @(negedge clk);
        checks++; if (ls_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL wait_single_pulse got=%b exp=0", ls_rvalid); end
        wait_states = 0;
    endtask

    task automatic test_reset_mid_busy();
        bit g;
        int ls_grants = 0;
        int stray = 0;
        // Build the starve count up to its limit: four load grants with a fetch waiting.
        wait_states = 0;
        if_req = 1'b1; if_addr = 32'h4;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h8;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (ls_gnt) ls_grants++;
            checks++; if (if_gnt) begin failures++; $display("[TB] FAIL starve_build_if cycle=%0d got=1 exp=0", c); end
            @(negedge clk);
        end
        if_req = 1'b0; ls_req = 1'b0;
        checks++; if (ls_grants != 4) begin failures++; $display("[TB] FAIL starve_build_count got=%0d exp=4", ls_grants); end
        wait_states = 3;
        drive_req(1'b1, 1'b0, 32'h0000_0008, 32'h0, 4'h0, g);
        checks++; if (!(g && mem_req)) begin failures++; $display("[TB] FAIL midreset_busy got=%b%b exp=11", g, mem_req); end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        checks++; if ({mem_req, ls_rvalid} !== 2'b00) begin failures++; $display("[TB] FAIL midreset_abort got=%b exp=00", {mem_req, ls_rvalid}); end
        checks++; if (ls_rdata !== 32'h0) begin failures++; $display("[TB] FAIL midreset_rdata got=%h exp=0", ls_rdata); end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ls_rvalid || mem_req) stray++;
        end
        checks++; if (stray != 0) begin failures++; $display("[TB] FAIL midreset_no_rvalid got=%0d exp=0", stray); end
        // Starve count cleared: load/store must win again over a waiting fetch.
        wait_states = 0;
        if_req = 1'b1; ls_req = 1'b1;
        #1;
        checks++; if ({ls_gnt, if_gnt} !== 2'b10) begin failures++; $display("[TB] FAIL postreset_first_grant got=%b exp=10", {ls_gnt, if_gnt}); end
        @(negedge clk);
        ls_req = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (if_gnt !== 1'b1) begin failures++; $display("[TB] FAIL postreset_if_gnt got=%b exp=1", if_gnt); end
        @(negedge clk);
        if_req = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        $display("[TB] mem_arbiter bench start");
        test_reset();
        test_fetch();
        test_store_load();
        test_contention();
        test_wait_states();
        test_reset_mid_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
